// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline types: NOP encoding, default widths, IF/ID entry, occupancy states
package mips_pipe_pkg;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_INSTR_WIDTH   = 32;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_INSTR_WIDTH-1:0]   instr;
        logic [DEF_ADDRESS_WIDTH-1:0] pcplus4;
        logic                         valid;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one pipeline entry (instr, pc+4, valid) with async clear, sync load and sync clear
module pipe_entry_reg #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     clear,
    input  logic [INSTR_WIDTH-1:0]   d_instr,
    input  logic [ADDRESS_WIDTH-1:0] d_pcplus4,
    output logic [INSTR_WIDTH-1:0]   q_instr,
    output logic [ADDRESS_WIDTH-1:0] q_pcplus4,
    output logic                     q_valid
);

    // Clear wins over load so a flush can never leave a half-written entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_instr   <= '0;
            q_pcplus4 <= '0;
            q_valid   <= 1'b0;
        end else if (clear) begin
            q_instr   <= '0;
            q_pcplus4 <= '0;
            q_valid   <= 1'b0;
        end else if (load) begin
            q_instr   <= d_instr;
            q_pcplus4 <= d_pcplus4;
            q_valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID 2-entry skid register; IFID_PERF_CNT_EN adds stall/flush counters
module if_id_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int INSTR_WIDTH   = DEF_INSTR_WIDTH
`ifdef IFID_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH     = 32
`endif
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [INSTR_WIDTH-1:0]   i_InstrF,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4F,
    input  logic                     i_ValidF,
    output logic                     o_ReadyF,
    input  logic                     i_FlushD,
    input  logic                     i_ReadyD,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     o_StallCnt,
    output logic [CNT_WIDTH-1:0]     o_FlushCnt
`endif
);

    occ_state_t state, state_nxt;

    logic                     out_valid, skid_valid;
    logic [INSTR_WIDTH-1:0]   out_instr, skid_instr, out_d_instr;
    logic [ADDRESS_WIDTH-1:0] out_pcplus4, skid_pcplus4, out_d_pcplus4;
    logic                     out_load, out_clear, skid_load, skid_clear, out_from_skid;
    logic                     in_fire, out_fire;

    assign o_ReadyF = ~skid_valid;
    assign o_ValidD = out_valid;
    assign in_fire  = i_ValidF & o_ReadyF;
    assign out_fire = out_valid & i_ReadyD;

    always_comb begin
        state_nxt     = state;
        out_load      = 1'b0;
        out_clear     = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        out_from_skid = 1'b0;
        if (i_FlushD) begin
            out_clear  = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = OCC_EMPTY;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        out_load  = 1'b1;
                        state_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        out_load = 1'b1;
                    end else if (out_fire) begin
                        out_clear = 1'b1;
                        state_nxt = OCC_EMPTY;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_nxt = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                        skid_clear    = 1'b1;
                        state_nxt     = OCC_ONE;
                    end
                end
                default: begin
                    out_clear  = 1'b1;
                    skid_clear = 1'b1;
                    state_nxt  = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) state <= OCC_EMPTY;
        else        state <= state_nxt;
    end

    assign out_d_instr   = out_from_skid ? skid_instr   : i_InstrF;
    assign out_d_pcplus4 = out_from_skid ? skid_pcplus4 : i_PCPlus4F;

    pipe_entry_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .INSTR_WIDTH   (INSTR_WIDTH)
    ) u_out (
        .clk       (i_CLK),
        .rst_n     (i_RST),
        .load      (out_load),
        .clear     (out_clear),
        .d_instr   (out_d_instr),
        .d_pcplus4 (out_d_pcplus4),
        .q_instr   (out_instr),
        .q_pcplus4 (out_pcplus4),
        .q_valid   (out_valid)
    );

    pipe_entry_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .INSTR_WIDTH   (INSTR_WIDTH)
    ) u_skid (
        .clk       (i_CLK),
        .rst_n     (i_RST),
        .load      (skid_load),
        .clear     (skid_clear),
        .d_instr   (i_InstrF),
        .d_pcplus4 (i_PCPlus4F),
        .q_instr   (skid_instr),
        .q_pcplus4 (skid_pcplus4),
        .q_valid   (skid_valid)
    );

    assign o_InstrD   = out_valid ? out_instr   : INSTR_WIDTH'(NOP_INSTR);
    assign o_PCPlus4D = out_valid ? out_pcplus4 : '0;

`ifdef IFID_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
    logic [1:0]           flush_drop;
    logic [CNT_WIDTH:0]   flush_sum;

    // An entry consumed in the flush cycle was delivered, so it is not counted.
    assign flush_drop = {1'b0, out_valid & ~out_fire} + {1'b0, skid_valid};
    assign flush_sum  = {1'b0, flush_cnt} + (CNT_WIDTH + 1)'(flush_drop);

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (i_ValidF && !o_ReadyF && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (i_FlushD)
                flush_cnt <= flush_sum[CNT_WIDTH] ? '1 : flush_sum[CNT_WIDTH-1:0];
        end
    end

    assign o_StallCnt = stall_cnt;
    assign o_FlushCnt = flush_cnt;
`endif

endmodule
